// File: rtl/div_core.sv
// rtl/div_core.sv - sequential restoring unsigned divider, one quotient bit per clock
module div_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem, dvd, dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_next, dvd_next;
  logic             launch, zero_launch, last;

  assign busy = (state == RUN);

  // One restoring step; the partial remainder stays below the divisor, so
  // WIDTH+1 bits suffice and the trial MSB is its sign.
  always_comb begin
    launch      = (state == IDLE) && start && (B != '0);
    zero_launch = (state == IDLE) && start && (B == '0);
    last        = (state == RUN) && (cnt == CW'(1));
    rem_sh      = {rem, dvd[WIDTH-1]};
    trial       = rem_sh - {1'b0, dsr};
    rem_next    = rem_sh[WIDTH-1:0];
    dvd_next    = {dvd[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      dvd_next = {dvd[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      Q    <= '0;
      R    <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        dvd <= A;
        dsr <= B;
        rem <= '0;
        cnt <= CW'(WIDTH);
      end else if (zero_launch) begin
        Q    <= '1;
        R    <= A;
        dbz  <= 1'b1;
        done <= 1'b1;
      end else if (state == RUN) begin
        rem <= rem_next;
        dvd <= dvd_next;
        cnt <= cnt - CW'(1);
        // Final step writes the result straight from the step logic.
        if (last) begin
          Q    <= dvd_next;
          R    <= rem_next;
          dbz  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_core.sv
// tb/tb_div_core.sv - self-checking bench for div_core
module tb_div_core;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B, Q, R;
  logic         busy, done, dbz;

  div_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: operation in flight counts down WIDTH edges, then the
  // result is plain integer division.
  bit         m_valid = 0;
  int         m_left  = 0;
  int         m_a, m_b;
  logic [W-1:0] e_q, e_r;
  logic       e_busy, e_done, e_dbz;

  always @(posedge clk) begin
    m_valid = 1;
    e_done  = 0;
    if (rst) begin
      m_left = 0; e_q = 0; e_r = 0; e_dbz = 0; e_busy = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e_q = W'(m_a / m_b); e_r = W'(m_a % m_b); e_dbz = 0; e_done = 1;
      end
      e_busy = (m_left > 0);
    end else if (start) begin
      if (B == 0) begin
        e_q = '1; e_r = A; e_dbz = 1; e_done = 1;
      end else begin
        m_left = W; m_a = int'(A); m_b = int'(B); e_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("Q", 32'(Q), 32'(e_q));
      chk("R", 32'(R), 32'(e_r));
      chk("dbz", 32'(dbz), 32'(e_dbz));
    end
  end

  task automatic start_op(input int a, input int b, output int se);
    start = 1'b1; A = W'(a); B = W'(b);
    @(posedge clk); #1;
    start = 1'b0;
    se = cyc;
  endtask

  task automatic wait_done(output int de);
    bit seen = 0;
    de = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; de = cyc; end
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic op_lit(input int a, input int b, input int eq, input int er,
                        input int edbz, input int elat, output int se, output int de);
    start_op(a, b, se);
    wait_done(de);
    chk("lit_Q", 32'(Q), 32'(eq));
    chk("lit_R", 32'(R), 32'(er));
    chk("lit_dbz", 32'(dbz), 32'(edbz));
    chk("latency", 32'(de - se), 32'(elat));
  endtask

  int se, de, prev_de, cnt_done;
  logic [W-1:0] cap_q, cap_r;

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Q", 32'(Q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    op_lit(9, 2, 4, 1, 0, W, se, de);

    // Back-to-back, each started in the preceding done cycle.
    op_lit(15, 3, 5, 0, 0, W, se, de);
    prev_de = de;
    op_lit(10, 4, 2, 2, 0, W, se, de);
    chk("b2b_issue1", 32'(se), 32'(prev_de + 1));
    prev_de = de;
    op_lit(5, 3, 1, 2, 0, W, se, de);
    chk("b2b_issue2", 32'(se), 32'(prev_de + 1));

    op_lit(8, 0, 15, 8, 1, 0, se, de);
    op_lit(7, 7, 1, 0, 0, W, se, de);

    // Start while busy is ignored.
    @(posedge clk); #1;
    start_op(9, 2, se);
    @(posedge clk); #1;
    start_op(1, 1, se);
    cnt_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin cnt_done++; cap_q = Q; cap_r = R; end
    end
    chk("ign_done_cnt", 32'(cnt_done), 32'(1));
    chk("ign_Q", 32'(cap_q), 32'(4));
    chk("ign_R", 32'(cap_r), 32'(1));

    // Reset mid-operation aborts it.
    start_op(12, 5, se);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("abort_done_cnt", 32'(cnt_done), 32'(0));
    chk("abort_Q", 32'(Q), 32'(0));
    chk("abort_R", 32'(R), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    op_lit(12, 5, 2, 2, 0, W, se, de);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) op_lit(a, b, 15, a, 1, 0, se, de);
        else        op_lit(a, b, a / b, a % b, 0, W, se, de);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
